// File: rtl/div_pkg.sv
// div_pkg: shared state type, width and sign helpers
// for the sequential signed restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIXUP,
    DONE
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] negate(
    input logic [DIV_WIDTH-1:0] x
  );
    return -x;
  endfunction

  // Unsigned magnitude; the most-negative value maps to 2^(W-1).
  function automatic logic [DIV_WIDTH-1:0] mag(
    input logic [DIV_WIDTH-1:0] x
  );
    return x[DIV_WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring iteration on
// the {A,Q} pair against the divisor magnitude V.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] aq,
  input  logic [WIDTH:0]     v,
  output logic [2*WIDTH-1:0] aq_nx
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] q_nx;

  assign a  = aq[2*WIDTH-1:WIDTH];
  assign q  = aq[WIDTH-1:0];
  assign sh = {a, q[WIDTH-1]};
  // A stays below V, so W+1 bits hold the signed trial difference.
  assign t  = sh - v;

  assign q_nx  = {q[WIDTH-2:0], ~t[WIDTH]};
  assign a_nx  = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
  assign aq_nx = {a_nx, q_nx};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: switch/button driven signed restoring divider,
// one quotient bit per clock, results held for display.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             LoadDividend,
  input  logic             LoadDivisor,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dividend,
  output logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t state;
  div_state_t state_nx;

  logic             start_q;
  logic             load;
  logic             go;
  logic             last;
  logic             zero_div;
  logic             ovf_case;
  logic             s_d;
  logic             s_v;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   v_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH:0]   dv_mag;
  logic [2*WIDTH-1:0] aq_nx;

  assign load     = LoadDividend | LoadDivisor;
  // Run sampled on one edge commits the start on the next.
  assign go       = (state == IDLE) && start_q;
  assign last     = cnt == CW'(WIDTH - 1);
  assign zero_div = Divisor == '0;
  assign ovf_case = (Dividend == {1'b1, {(WIDTH-1){1'b0}}})
                 && (Divisor == '1);

  assign dd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dv_mag = {1'b0, Divisor[WIDTH-1] ? -Divisor : Divisor};

  div_step #(.WIDTH(WIDTH)) u_step (
    .aq    ({a_r, q_r}),
    .v     (v_r),
    .aq_nx (aq_nx)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = SETUP;
      SETUP:   state_nx = zero_div ? DONE : ITER;
      ITER:    if (last) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    if (!Run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Busy = state inside {SETUP, ITER, FIXUP};
  assign Done = state == DONE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      Dividend  <= '0;
      Divisor   <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Ovf       <= 1'b0;
      s_d       <= 1'b0;
      s_v       <= 1'b0;
      a_r       <= '0;
      q_r       <= '0;
      v_r       <= '0;
      cnt       <= '0;
    end else begin
      state   <= state_nx;
      start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            DivZero   <= 1'b0;
            Ovf       <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
          end else begin
            start_q <= Run && !load;
            if (LoadDividend) Dividend <= Din;
            if (LoadDivisor)  Divisor  <= Din;
          end
        end
        SETUP: begin
          s_d <= Dividend[WIDTH-1];
          s_v <= Divisor[WIDTH-1];
          a_r <= '0;
          q_r <= dd_mag;
          v_r <= dv_mag;
          cnt <= '0;
          if (zero_div) begin
            DivZero   <= 1'b1;
            Quotient  <= '1;
            Remainder <= Dividend;
          end
        end
        ITER: begin
          {a_r, q_r} <= aq_nx;
          cnt        <= cnt + CW'(1);
        end
        FIXUP: begin
          if (ovf_case) begin
            Ovf       <= 1'b1;
            Quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
            Remainder <= '0;
          end else begin
            Quotient  <= (s_d ^ s_v) ? -q_r : q_r;
            Remainder <= s_d ? -a_r : a_r;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random operations checked
// every cycle against an arithmetic model of the divider.
module tb_seq_divider;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic         LoadDividend;
  logic         LoadDivisor;
  logic [W-1:0] Din;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic         Ovf;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .LoadDividend (LoadDividend),
    .LoadDivisor  (LoadDivisor),
    .Din          (Din),
    .Dividend     (Dividend),
    .Divisor      (Divisor),
    .Quotient     (Quotient),
    .Remainder    (Remainder),
    .Busy         (Busy),
    .Done         (Done),
    .DivZero      (DivZero),
    .Ovf          (Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } res_t;

  // Signed division from plain integer arithmetic.
  function automatic res_t divide(input logic [W-1:0] dd, dv);
    res_t res;
    int a;
    int b;
    a = int'($signed(dd));
    b = int'($signed(dv));
    res = '0;
    if (b == 0) begin
      res.q  = '1;
      res.r  = dd;
      res.dz = 1'b1;
    end else if (a == -(1 << (W - 1)) && b == -1) begin
      res.q   = dd;
      res.r   = '0;
      res.ovf = 1'b1;
    end else begin
      res.q = W'(a / b);
      res.r = W'(a % b);
    end
    return res;
  endfunction

  // Model: 0 idle, 1 running (m_t edges since the Run edge), 2 done.
  int           m_mode;
  int           m_t;
  logic [W-1:0] m_dd;
  logic [W-1:0] m_dv;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic         m_dz;
  logic         m_ovf;
  res_t         m_res;

  assign m_res = divide(m_dd, m_dv);

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode <= 0;
      m_t    <= 0;
      m_dd   <= '0;
      m_dv   <= '0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (LoadDividend || LoadDivisor) begin
            if (LoadDividend) m_dd <= Din;
            if (LoadDivisor)  m_dv <= Din;
          end else if (Run) begin
            m_mode <= 1;
            m_t    <= 0;
          end
        end
        1: begin
          m_t <= m_t + 1;
          if (m_t + 1 == ((m_dv == '0) ? 2 : W + 3)) begin
            m_q    <= m_res.q;
            m_r    <= m_res.r;
            m_dz   <= m_res.dz;
            m_ovf  <= m_res.ovf;
            m_mode <= 2;
          end else if (m_t + 1 == 1) begin
            m_q   <= '0;
            m_r   <= '0;
            m_dz  <= 1'b0;
            m_ovf <= 1'b0;
          end
        end
        default: if (!Run) m_mode <= 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    chk("dividend", int'(Dividend), int'(m_dd));
    chk("divisor", int'(Divisor), int'(m_dv));
    chk("quotient", int'(Quotient), int'(m_q));
    chk("remainder", int'(Remainder), int'(m_r));
    chk("busy", int'(Busy), int'(m_mode == 1 && m_t >= 1));
    chk("done", int'(Done), int'(m_mode == 2));
    chk("divzero", int'(DivZero), int'(m_dz));
    chk("ovf", int'(Ovf), int'(m_ovf));
    chk("busy_done_excl", int'(Busy && Done), 0);
  end

  task automatic op(input logic [W-1:0] dd, dv, input int lat,
                    input bit lit, input logic [W-1:0] qe, re,
                    input bit dze, ove, input bit rnd);
    int  k;
    bit  seen;
    @(posedge Clk); #1;
    Din = dd; LoadDividend = 1'b1;
    @(posedge Clk); #1;
    LoadDividend = 1'b0; Din = dv; LoadDivisor = 1'b1;
    @(posedge Clk); #1;
    LoadDivisor = 1'b0; Run = 1'b1;
    k = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      @(posedge Clk); #1;
      if (Done) begin
        seen = 1'b1;
      end else begin
        k++;
        if (rnd && k >= 2) begin
          LoadDividend = 1'($urandom_range(0, 1));
          LoadDivisor  = 1'($urandom_range(0, 1));
          Din          = W'($urandom);
        end
      end
    end
    LoadDividend = 1'b0;
    LoadDivisor  = 1'b0;
    chk("latency", k, lat);
    if (lit) begin
      chk("lit_quotient", int'(Quotient), int'(qe));
      chk("lit_remainder", int'(Remainder), int'(re));
      chk("lit_divzero", int'(DivZero), int'(dze));
      chk("lit_ovf", int'(Ovf), int'(ove));
      chk("lit_dividend", int'(Dividend), int'(dd));
      chk("lit_divisor", int'(Divisor), int'(dv));
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_done", int'(Done), 1);
    Run = 1'b0;
    @(posedge Clk); #1;
    chk("release_idle", int'(Done), 0);
    if (lit) chk("kept_quotient", int'(Quotient), int'(qe));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] tbl [6];
    tbl = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h81};
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    Reset = 1'b0;
    Run = 1'b0;
    LoadDividend = 1'b0;
    LoadDivisor = 1'b0;
    Din = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_quotient", int'(Quotient), 0);
    chk("rst_dividend", int'(Dividend), 0);
    Reset = 1'b1;

    op(8'h64, 8'h07, 11, 1, 8'h0E, 8'h02, 0, 0, 0);
    op(8'h9C, 8'h07, 11, 1, 8'hF2, 8'hFE, 0, 0, 0);
    op(8'h64, 8'hF9, 11, 1, 8'hF2, 8'h02, 0, 0, 0);
    op(8'h37, 8'h00, 2, 1, 8'hFF, 8'h37, 1, 0, 0);
    op(8'h80, 8'hFF, 11, 1, 8'h80, 8'h00, 0, 1, 0);

    // Load together with Run loads but does not start.
    @(posedge Clk); #1;
    Din = 8'h01; LoadDivisor = 1'b1; Run = 1'b1;
    @(posedge Clk); #1;
    LoadDivisor = 1'b0; Run = 1'b0;
    chk("load_run_busy", int'(Busy), 0);
    chk("load_run_divisor", int'(Divisor), 1);
    op(8'h80, 8'h01, 11, 1, 8'h80, 8'h00, 0, 0, 0);

    // Asynchronous reset during the fourth iteration.
    @(posedge Clk); #1;
    Din = 8'h64; LoadDividend = 1'b1;
    @(posedge Clk); #1;
    LoadDividend = 1'b0; Din = 8'h07; LoadDivisor = 1'b1;
    @(posedge Clk); #1;
    LoadDivisor = 1'b0; Run = 1'b1;
    repeat (7) @(posedge Clk);
    #1;
    chk("mid_busy", int'(Busy), 1);
    #1;
    Reset = 1'b0;
    Run = 1'b0;
    #1;
    chk("arst_busy", int'(Busy), 0);
    chk("arst_done", int'(Done), 0);
    chk("arst_dividend", int'(Dividend), 0);
    chk("arst_divisor", int'(Divisor), 0);
    chk("arst_quotient", int'(Quotient), 0);
    chk("arst_remainder", int'(Remainder), 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    op(8'h09, 8'h03, 11, 1, 8'h03, 8'h00, 0, 0, 0);

    op(8'h64, 8'h07, 11, 1, 8'h0E, 8'h02, 0, 0, 1);
    op(8'h64, 8'h07, 11, 1, 8'h0E, 8'h02, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = pick();
      b = pick();
      op(a, b, (b == '0) ? 2 : 11, 0, '0, '0, 0, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential signed restoring divider, the inverse companion of the team's shift-add multiplier. It uses the same switch/button operator interface: operands are loaded from Din, Run starts the operation, and results are held for the hex displays. One quotient bit is produced per clock, so an operation takes WIDTH+3 clocks, followed by a hold state until Run is released.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Run  input  1  start request, active high, level
LoadDividend  input  1  capture Din into dividend register (IDLE only)
LoadDivisor  input  1  capture Din into divisor register (IDLE only)
Din  input  WIDTH  operand data from switches
Dividend  output  WIDTH  current dividend register (for display)
Divisor  output  WIDTH  current divisor register (for display)
Quotient  output  WIDTH  signed quotient, valid while Done=1
Remainder  output  WIDTH  signed remainder, valid while Done=1
Busy  output  1  high in SETUP/ITER/FIXUP
Done  output  1  high in DONE
DivZero  output  1  divisor was zero (sticky until next start)
Ovf  output  1  most-negative / -1 overflow (sticky until next start)

Behaviour:
- Reset=0, at any time including mid-operation: state IDLE; all registers and outputs 0.
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE:
  - LoadDividend/LoadDivisor capture Din on the clock edge; both may load the same cycle.
  - If both a Load and Run are high, the load takes effect and the FSM stays in IDLE that cycle.
  - Run=1 with no Load → SETUP. On entry, clear DivZero, Ovf, Quotient and Remainder.
- SETUP (1 clk):
  - Latch sign bits sD (dividend) and sV (divisor).
  - A ← 0, Q ← |dividend|, V ← |divisor|. V is WIDTH+1 bits so |most-negative| is representable.
  - cnt ← 0.
  - If divisor==0: DivZero←1, Quotient←all ones, Remainder←dividend, → DONE.
  - Else → ITER.
- ITER (exactly WIDTH clks, one per edge):
  - {A,Q} shifted left by 1.
  - T = A − V, computed WIDTH+1 bits wide.
  - If T ≥ 0: A←T, Q[0]←1. Else: A unchanged (restored), Q[0]←0.
  - cnt++. After the WIDTH-th step → FIXUP.
- FIXUP (1 clk):
  - Quotient ← (sD^sV) ? −Q : Q, truncated toward zero.
  - Remainder ← sD ? −A : A, so the remainder takes the dividend's sign.
  - Ovf←1 iff dividend = 100…0 and divisor = all ones. In that case Quotient = 100…0 (wrapped), Remainder=0.
  - → DONE.
- DONE:
  - Results and flags held stable; Loads ignored.
  - Stay while Run=1. Run=0 → IDLE; results stay visible until the next start.
- Loads are ignored outside IDLE.
- Dividend/Divisor registers are never modified by the operation.
- Run held high continuously gives exactly one operation; a new start requires Run to go low, then high.
- Latency: the edge sampling Run=1 is edge 0. Done=1 after edge WIDTH+3 (edge 11 for WIDTH=8). Divide-by-zero gives Done=1 after edge 2.
- Busy and Done are never high together.
- Invariant (non-error cases): Dividend = Quotient·Divisor + Remainder, and |Remainder| < |Divisor|.

Decomposition:
- Package div_pkg:
  - state enum type div_state_t {IDLE, SETUP, ITER, FIXUP, DONE}
  - localparam DIV_WIDTH = 8
  - function abs/negate helpers
- Sub-module div_step: combinational single restoring iteration.
  - Inputs {A,Q}, V.
  - Outputs next {A,Q}.
- Top seq_divider holds the FSM, counter, operand registers and sign/fixup logic.

Test Plan:
1. Load 100 (0x64) / 7, Run → Done after 11 clks; Quotient=0x0E, Remainder=0x02; Busy high for clks 1–10.
2. −100 (0x9C) / 7 → Quotient=0xF2 (−14), Remainder=0xFE (−2). Then 100 / −7 (0xF9) → Quotient=0xF2, Remainder=0x02.
3. −128 (0x80) / −1 (0xFF) → Ovf=1, Quotient=0x80, Remainder=0x00. Then −128 / 1 → Quotient=0x80, Ovf=0.
4. 55 / 0 → Done after 2 clks, DivZero=1, Quotient=0xFF, Remainder=0x37. The next valid start clears DivZero.
5. Reset=0 asserted asynchronously at ITER step 4 → all outputs 0 immediately, state IDLE. Reload 9 / 3, Run → Quotient=0x03, Remainder=0x00.
6. Run held high through DONE → no restart and results stable. Loads during Busy leave Dividend/Divisor unchanged. Drop Run, then raise it → the second operation repeats identical results.
